// File: rtl/qlearn_pkg.sv
// Shared Q-learning definitions: default widths, scanner FSM encoding and
// the Q-table {state, action} address helper.
package qlearn_pkg;

  localparam int QL_STATE_WIDTH = 4;
  localparam int QL_ACT_WIDTH   = 2;
  localparam int QL_DATA_WIDTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } qmax_state_t;

  // Callers truncate the result to STATE_WIDTH+ACT_WIDTH bits.
  function automatic logic [31:0] q_addr(input logic [31:0] state,
                                         input logic [31:0] act,
                                         input int          act_w);
    return (state << act_w) | act;
  endfunction

endpackage

// File: rtl/qmax_scan_if.sv
// Request, Q-value read port and Q-max write port of the per-state max scanner.
interface qmax_scan_if #(
  parameter int STATE_WIDTH = 4,
  parameter int ACT_WIDTH   = 2,
  parameter int DATA_WIDTH  = 32
);
  logic                           i_start;
  logic [STATE_WIDTH-1:0]         i_state;
  logic                           o_busy;
  logic                           o_done;
  logic                           o_q_rd_en;
  logic [STATE_WIDTH+ACT_WIDTH-1:0] o_q_rd_addr;
  logic [DATA_WIDTH-1:0]          i_q_rd_data;
  logic                           o_max_wr_en;
  logic [STATE_WIDTH-1:0]         o_max_wr_addr;
  logic [DATA_WIDTH-1:0]          o_max_wr_data;
  logic [ACT_WIDTH-1:0]           o_argmax;

  modport slave (
    input  i_start, i_state, i_q_rd_data,
    output o_busy, o_done, o_q_rd_en, o_q_rd_addr,
           o_max_wr_en, o_max_wr_addr, o_max_wr_data, o_argmax
  );

  modport master (
    output i_start, i_state, i_q_rd_data,
    input  o_busy, o_done, o_q_rd_en, o_q_rd_addr,
           o_max_wr_en, o_max_wr_addr, o_max_wr_data, o_argmax
  );
endinterface

// File: rtl/qmax_cmp.sv
// Registered signed max/argmax tracker. QMAX_TIE_LAST_EN switches the compare
// to >= so ties go to the highest action index instead of the lowest.
module qmax_cmp #(
  parameter int ACT_WIDTH  = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_vld,
  input  logic                  i_first,
  input  logic [ACT_WIDTH-1:0]  i_idx,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_max,
  output logic [ACT_WIDTH-1:0]  o_argmax
);

  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [ACT_WIDTH-1:0]  arg_q, arg_d;
  logic                  take;

  always_comb begin
`ifdef QMAX_TIE_LAST_EN
    take = i_first || ($signed(i_data) >= $signed(max_q));
`else
    take = i_first || ($signed(i_data) > $signed(max_q));
`endif
    max_d = max_q;
    arg_d = arg_q;
    if (i_vld && take) begin
      max_d = i_data;
      arg_d = i_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      max_q <= '0;
      arg_q <= '0;
    end else begin
      max_q <= max_d;
      arg_q <= arg_d;
    end
  end

  assign o_max    = max_q;
  assign o_argmax = arg_q;

endmodule

// File: rtl/qmax_scan.sv
// Per-state Q maximum scanner: reads all actions of one state, then writes the
// signed maximum to the Q-max table. Tie policy set by QMAX_TIE_LAST_EN.
module qmax_scan
  import qlearn_pkg::*;
#(
  parameter int STATE_WIDTH = QL_STATE_WIDTH,
  parameter int ACT_WIDTH   = QL_ACT_WIDTH,
  parameter int NUM_ACTIONS = 4,
  parameter int DATA_WIDTH  = QL_DATA_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_rst,
  qmax_scan_if.slave    bus
);

  localparam int ADDR_WIDTH = STATE_WIDTH + ACT_WIDTH;
  localparam logic [ACT_WIDTH-1:0] LAST_ACT = ACT_WIDTH'(NUM_ACTIONS - 1);

  qmax_state_t            fsm_q, fsm_d;
  logic [STATE_WIDTH-1:0] st_q, st_d;
  logic [ACT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   vld_q, vld_d;
  logic [ACT_WIDTH-1:0]   idx_q, idx_d;
  logic [ACT_WIDTH-1:0]   arg_hold_q, arg_hold_d;
  logic [DATA_WIDTH-1:0]  cmp_max;
  logic [ACT_WIDTH-1:0]   cmp_arg;

  // Terminal count is tested before incrementing, so cnt never wraps.
  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          st_d  = bus.i_state;
          cnt_d = '0;
          fsm_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cnt_q == LAST_ACT) fsm_d = ST_DRAIN;
        else                   cnt_d = cnt_q + 1'b1;
      end
      ST_DRAIN: fsm_d = ST_WRITE;
      ST_WRITE: fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_d      = (fsm_q == ST_SCAN);
    idx_d      = cnt_q;
    arg_hold_d = (fsm_q == ST_WRITE) ? cmp_arg : arg_hold_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_q      <= ST_IDLE;
      st_q       <= '0;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
      idx_q      <= '0;
      arg_hold_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      idx_q      <= idx_d;
      arg_hold_q <= arg_hold_d;
    end
  end

  qmax_cmp #(
    .ACT_WIDTH  (ACT_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_vld    (vld_q),
    .i_first  (vld_q && (idx_q == '0)),
    .i_idx    (idx_q),
    .i_data   (bus.i_q_rd_data),
    .o_max    (cmp_max),
    .o_argmax (cmp_arg)
  );

  // argmax shows the fresh result during WRITE, then holds it until the next write.
  assign bus.o_busy        = (fsm_q != ST_IDLE);
  assign bus.o_done        = (fsm_q == ST_WRITE);
  assign bus.o_q_rd_en     = (fsm_q == ST_SCAN);
  assign bus.o_q_rd_addr   = ADDR_WIDTH'(q_addr(32'(st_q), 32'(cnt_q), ACT_WIDTH));
  assign bus.o_max_wr_en   = (fsm_q == ST_WRITE);
  assign bus.o_max_wr_addr = st_q;
  assign bus.o_max_wr_data = cmp_max;
  assign bus.o_argmax      = (fsm_q == ST_WRITE) ? cmp_arg : arg_hold_q;

endmodule

// File: tb/tb_qmax_scan.sv
// Directed bench for qmax_scan: a 4-action instance and a 1-action instance
// share a behavioural Q-value table with registered reads.
module tb_qmax_scan;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   wr_count_a = 0;
  int   done_count_a = 0;

  logic [31:0] qmem [0:63];

`ifdef QMAX_TIE_LAST_EN
  localparam logic [1:0] ARG_S0 = 2'd2;
  localparam logic [1:0] ARG_S2 = 2'd1;
`else
  localparam logic [1:0] ARG_S0 = 2'd1;
  localparam logic [1:0] ARG_S2 = 2'd0;
`endif

  qmax_scan_if #(.STATE_WIDTH(4), .ACT_WIDTH(2), .DATA_WIDTH(32)) bus_a ();
  qmax_scan_if #(.STATE_WIDTH(4), .ACT_WIDTH(2), .DATA_WIDTH(32)) bus_b ();

  qmax_scan #(.STATE_WIDTH(4), .ACT_WIDTH(2), .NUM_ACTIONS(4), .DATA_WIDTH(32)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a)
  );

  qmax_scan #(.STATE_WIDTH(4), .ACT_WIDTH(2), .NUM_ACTIONS(1), .DATA_WIDTH(32)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_a.o_q_rd_en) bus_a.i_q_rd_data <= qmem[bus_a.o_q_rd_addr];
    if (bus_b.o_q_rd_en) bus_b.i_q_rd_data <= qmem[bus_b.o_q_rd_addr];
    if (bus_a.o_max_wr_en) wr_count_a <= wr_count_a + 1;
    if (bus_a.o_done) done_count_a <= done_count_a + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_busy"},    32'(bus_a.o_busy), 32'd0);
    check({tag, "_done"},    32'(bus_a.o_done), 32'd0);
    check({tag, "_rd_en"},   32'(bus_a.o_q_rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(bus_a.o_q_rd_addr), 32'd0);
    check({tag, "_wr_en"},   32'(bus_a.o_max_wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(bus_a.o_max_wr_addr), 32'd0);
    check({tag, "_wr_data"}, bus_a.o_max_wr_data, 32'd0);
    check({tag, "_argmax"},  32'(bus_a.o_argmax), 32'd0);
  endtask

  // Full scan on instance A; a start pulse with another state is injected
  // during SCAN cycle 'poke' (poke < 0 disables it).
  task automatic scan_a(input string tag, input logic [3:0] st, input logic [31:0] exp_max,
                        input logic [1:0] exp_arg, input int poke);
    bus_a.i_state = st;
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    for (int a = 0; a < 4; a++) begin
      if (a == poke) begin
        bus_a.i_start = 1'b1;
        bus_a.i_state = st ^ 4'hF;
      end else begin
        bus_a.i_start = 1'b0;
      end
      check({tag, "_rd_en"},   32'(bus_a.o_q_rd_en), 32'd1);
      check({tag, "_rd_addr"}, 32'(bus_a.o_q_rd_addr), 32'({st, 2'(a)}));
      tick();
    end
    bus_a.i_start = 1'b0;
    bus_a.i_state = st;
    check({tag, "_drain_rd_en"}, 32'(bus_a.o_q_rd_en), 32'd0);
    check({tag, "_drain_wr_en"}, 32'(bus_a.o_max_wr_en), 32'd0);
    check({tag, "_drain_busy"},  32'(bus_a.o_busy), 32'd1);
    tick();
    check({tag, "_wr_en"},   32'(bus_a.o_max_wr_en), 32'd1);
    check({tag, "_wr_addr"}, 32'(bus_a.o_max_wr_addr), 32'(st));
    check({tag, "_wr_data"}, bus_a.o_max_wr_data, exp_max);
    check({tag, "_argmax"},  32'(bus_a.o_argmax), 32'(exp_arg));
    check({tag, "_done"},    32'(bus_a.o_done), 32'd1);
    check({tag, "_busy"},    32'(bus_a.o_busy), 32'd1);
    tick();
    check({tag, "_idle_busy"},   32'(bus_a.o_busy), 32'd0);
    check({tag, "_idle_done"},   32'(bus_a.o_done), 32'd0);
    check({tag, "_idle_wr_en"},  32'(bus_a.o_max_wr_en), 32'd0);
    check({tag, "_hold_argmax"}, 32'(bus_a.o_argmax), 32'(exp_arg));
    $display("scan %s state=%0d max=%0h argmax=%0d", tag, st, bus_a.o_max_wr_data, bus_a.o_argmax);
  endtask

  initial begin
    int w0;
    int d0;
    int first_wr;
    int second_wr;
    int rd2;
    int n_wr;

    for (int i = 0; i < 64; i++) qmem[i] = 32'd0;
    qmem[12] = 32'd5;  qmem[13] = -32'sd2;  qmem[14] = 32'd17; qmem[15] = 32'd9;
    qmem[0]  = -32'sd8; qmem[1] = -32'sd3;  qmem[2]  = -32'sd3; qmem[3] = -32'sd100;
    qmem[16] = -32'sd1; qmem[17] = -32'sd5; qmem[18] = -32'sd9; qmem[19] = 32'h8000_0000;
    qmem[32] = 32'h8000_0000; qmem[33] = 32'h7FFF_FFFF; qmem[34] = 32'd0; qmem[35] = 32'd1;
    qmem[24] = 32'd10; qmem[25] = 32'd20; qmem[26] = 32'd30; qmem[27] = 32'd40;
    qmem[4]  = 32'd3;  qmem[5] = -32'sd4;   qmem[6] = 32'd11;  qmem[7] = 32'd2;
    qmem[8]  = -32'sd6; qmem[9] = -32'sd6;  qmem[10] = -32'sd7; qmem[11] = -32'sd9;
    qmem[20] = 32'd42;

    rst = 1'b1;
    bus_a.i_start = 1'b0; bus_a.i_state = 4'd0;
    bus_b.i_start = 1'b0; bus_b.i_state = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_a_zero("reset");
    check("reset_b_busy", 32'(bus_b.o_busy), 32'd0);

    scan_a("s3", 4'd3, 32'd17, 2'd2, -1);
    scan_a("s0_neg_tie", 4'd0, -32'sd3, ARG_S0, -1);
    scan_a("s4_min_last", 4'd4, -32'sd1, 2'd0, -1);
    scan_a("s8_extremes", 4'd8, 32'h7FFF_FFFF, 2'd1, -1);

    w0 = wr_count_a;
    scan_a("s6_poke", 4'd6, 32'd40, 2'd3, 1);
    for (int i = 0; i < 6; i++) tick();
    check("poke_one_write", 32'(wr_count_a - w0), 32'd1);
    check("poke_still_idle", 32'(bus_a.o_busy), 32'd0);

    // Abort a scan with reset in its third cycle.
    w0 = wr_count_a;
    d0 = done_count_a;
    bus_a.i_state = 4'd3;
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_a_zero("abort");
    for (int i = 0; i < 8; i++) tick();
    check("abort_no_write", 32'(wr_count_a - w0), 32'd0);
    check("abort_no_done", 32'(done_count_a - d0), 32'd0);
    $display("abort writes=%0d dones=%0d", wr_count_a - w0, done_count_a - d0);
    scan_a("s3_after_abort", 4'd3, 32'd17, 2'd2, -1);

    // Back-to-back scans with start held high.
    first_wr = -1; second_wr = -1; rd2 = -1; n_wr = 0;
    bus_a.i_state = 4'd1;
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_state = 4'd2;
    for (int k = 1; k <= 16; k++) begin
      if (k == 9) bus_a.i_start = 1'b0;
      if (bus_a.o_max_wr_en) begin
        if (n_wr == 0) begin
          first_wr = k;
          check("b2b_wr1_addr", 32'(bus_a.o_max_wr_addr), 32'd1);
          check("b2b_wr1_data", bus_a.o_max_wr_data, 32'd11);
          check("b2b_wr1_arg",  32'(bus_a.o_argmax), 32'd2);
        end else begin
          second_wr = k;
          check("b2b_wr2_addr", 32'(bus_a.o_max_wr_addr), 32'd2);
          check("b2b_wr2_data", bus_a.o_max_wr_data, -32'sd6);
          check("b2b_wr2_arg",  32'(bus_a.o_argmax), 32'(ARG_S2));
        end
        $display("b2b write k=%0d addr=%0d data=%0h argmax=%0d", k,
                 bus_a.o_max_wr_addr, bus_a.o_max_wr_data, bus_a.o_argmax);
        n_wr++;
      end
      if (bus_a.o_q_rd_en && bus_a.o_q_rd_addr == 6'd8 && rd2 < 0) rd2 = k;
      tick();
    end
    check("b2b_write_count", 32'(n_wr), 32'd2);
    check("b2b_first_write", 32'(first_wr), 32'd6);
    check("b2b_second_reads", 32'(rd2), 32'd8);
    check("b2b_write_gap", 32'(second_wr - first_wr), 32'd7);

    // Single-action instance.
    bus_b.i_state = 4'd5;
    bus_b.i_start = 1'b1;
    tick();
    bus_b.i_start = 1'b0;
    check("n1_rd_en",   32'(bus_b.o_q_rd_en), 32'd1);
    check("n1_rd_addr", 32'(bus_b.o_q_rd_addr), 32'd20);
    tick();
    check("n1_drain_rd_en", 32'(bus_b.o_q_rd_en), 32'd0);
    check("n1_drain_wr_en", 32'(bus_b.o_max_wr_en), 32'd0);
    tick();
    check("n1_wr_en",   32'(bus_b.o_max_wr_en), 32'd1);
    check("n1_wr_addr", 32'(bus_b.o_max_wr_addr), 32'd5);
    check("n1_wr_data", bus_b.o_max_wr_data, 32'd42);
    check("n1_argmax",  32'(bus_b.o_argmax), 32'd0);
    check("n1_done",    32'(bus_b.o_done), 32'd1);
    $display("scan n1 state=5 max=%0h argmax=%0d", bus_b.o_max_wr_data, bus_b.o_argmax);
    tick();
    check("n1_idle_busy", 32'(bus_b.o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
